// File: rtl/cache_pkg.sv
// Shared definitions for the write-back fully associative cache: controller
// state encoding and the width of the per-line age field.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Bits needed to hold an age (or a way index) for a given number of lines.
    function automatic int age_width(input int ways);
        return (ways <= 1) ? 1 : $clog2(ways);
    endfunction

endpackage

// File: rtl/cache_lru_ages.sv
// Per-line age tracker. Ages form a permutation of 0..WAYS-1; the line whose
// age is WAYS-1 is the least recently used one and is offered as the victim.
module cache_lru_ages
    import cache_pkg::*;
#(
    parameter int WAYS = 4,
    localparam int AGE_W = age_width(WAYS)
) (
    input  logic             clock1,
    input  logic             Reset,
    input  logic             i_access,
    input  logic [AGE_W-1:0] i_way,
    output logic [AGE_W-1:0] o_victim
);

    logic [AGE_W-1:0] r_age [WAYS];

    // Age update: accessed line becomes youngest, lines younger than it get one older.
    // NOTE: the ages are reset (unlike the data array) because victim choice
    // depends on them forming a permutation from the very first miss.
    always_ff @(posedge clock1) begin
        if (Reset) begin
            for (int i = 0; i < WAYS; i++) begin
                // NOTE: sequential state uses non-blocking assignments so every
                // line sees the pre-edge age of the accessed line.
                r_age[i] <= AGE_W'(i);
            end
        end else if (i_access) begin
            // Lines still invalid always hold ages above every valid line, so
            // comparing against all lines is identical to comparing valid ones.
            for (int i = 0; i < WAYS; i++) begin
                if (AGE_W'(i) == i_way) begin
                    r_age[i] <= '0;
                end else if (r_age[i] < r_age[i_way]) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end

    // Victim: the line holding the oldest age.
    always_comb begin
        // NOTE: default first so no path through the loop leaves o_victim
        // unassigned, which would infer a latch.
        o_victim = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (r_age[i] == AGE_W'(WAYS - 1)) begin
                o_victim = AGE_W'(i);
            end
        end
    end

endmodule

// File: rtl/cache_assoc_wb.sv
// Fully associative write-back, write-allocate cache with a single outstanding
// memory transaction (writeback of a dirty victim, then refill on read misses).
module cache_assoc_wb
    import cache_pkg::*;
#(
    parameter int WAYS   = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 8
) (
    input  logic              clock1,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_req_valid,
    output logic              mem_req_write,
    output logic [TAG_W-1:0]  mem_req_tag,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int AGE_W = age_width(WAYS);

    state_t            r_state, w_next;
    logic [WAYS-1:0]   r_valid, r_dirty;
    logic [TAG_W-1:0]  r_tag  [WAYS];
    logic [DATA_W-1:0] r_data [WAYS];

    logic              r_write;
    logic [TAG_W-1:0]  r_req_tag;
    logic [DATA_W-1:0] r_req_wdata;
    logic [AGE_W-1:0]  r_way;
    logic              r_resp_hit;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_mem_valid, r_mem_write;
    logic [TAG_W-1:0]  r_mem_tag;
    logic [DATA_W-1:0] r_mem_wdata;

    logic [WAYS-1:0]   w_match;
    logic              w_hit, w_has_invalid, w_accept, w_mem_done;
    logic [AGE_W-1:0]  w_hit_way, w_invalid_way, w_lru_way, w_victim;
    logic              w_line_we, w_line_dirty, w_access;
    logic [AGE_W-1:0]  w_line_way, w_access_way;
    logic [TAG_W-1:0]  w_line_tag;
    logic [DATA_W-1:0] w_line_data;

    assign w_accept   = req_valid && (r_state == ST_IDLE);
    assign w_mem_done = mem_ack && r_mem_valid;
    assign w_victim   = w_has_invalid ? w_invalid_way : w_lru_way;

    cache_lru_ages #(.WAYS(WAYS)) u_ages (
        .clock1   (clock1),
        .Reset    (Reset),
        .i_access (w_access && !Reset),
        .i_way    (w_access_way),
        .o_victim (w_lru_way)
    );

    // Tag lookup and lowest-index invalid line search.
    always_comb begin
        w_match       = '0;
        w_hit_way     = '0;
        w_has_invalid = 1'b0;
        w_invalid_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            w_match[i] = r_valid[i] && (r_tag[i] == req_tag);
            if (w_match[i]) w_hit_way = AGE_W'(i);
            if (!r_valid[i]) begin
                w_has_invalid = 1'b1;
                w_invalid_way = AGE_W'(i);
            end
        end
        w_hit = ($countones(w_match) == 1);
    end

    // Line write and age-access strobes for write hits, installs and read hits.
    always_comb begin
        w_line_we    = 1'b0;
        w_line_way   = r_way;
        w_line_tag   = r_req_tag;
        w_line_data  = r_req_wdata;
        w_line_dirty = 1'b1;
        w_access     = 1'b0;
        w_access_way = r_way;
        unique case (r_state)
            ST_IDLE: if (req_valid) begin
                if (w_hit) begin
                    w_access     = 1'b1;
                    w_access_way = w_hit_way;
                    w_line_we    = req_write;
                    w_line_way   = w_hit_way;
                    w_line_tag   = req_tag;
                    w_line_data  = req_wdata;
                end else if (req_write && !r_dirty[w_victim]) begin
                    w_access     = 1'b1;
                    w_access_way = w_victim;
                    w_line_we    = 1'b1;
                    w_line_way   = w_victim;
                    w_line_tag   = req_tag;
                    w_line_data  = req_wdata;
                end
            end
            ST_WB: if (w_mem_done && r_write) begin
                w_line_we = 1'b1;
                w_access  = 1'b1;
            end
            ST_FILL: if (w_mem_done) begin
                w_line_we    = 1'b1;
                w_line_data  = mem_rdata;
                w_line_dirty = 1'b0;
                w_access     = 1'b1;
            end
            default: ;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clock1) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (req_valid) begin
                if (w_hit)                  w_next = ST_RESP;
                else if (r_dirty[w_victim]) w_next = ST_WB;
                else if (req_write)         w_next = ST_RESP;
                else                        w_next = ST_FILL;
            end
            ST_WB:   if (w_mem_done) w_next = r_write ? ST_RESP : ST_FILL;
            ST_FILL: if (w_mem_done) w_next = ST_RESP;
            default: w_next = ST_IDLE;
        endcase
    end

    // Tag/data array: no reset, contents are qualified by the valid bits.
    // NOTE: leaving the array out of reset lets it map onto plain storage.
    always_ff @(posedge clock1) begin
        if (w_line_we && !Reset) begin
            r_tag[w_line_way]  <= w_line_tag;
            r_data[w_line_way] <= w_line_data;
        end
    end

    // Line status, latched request, response and memory-request registers.
    always_ff @(posedge clock1) begin
        if (Reset) begin
            r_valid      <= '0;
            r_dirty      <= '0;
            r_write      <= 1'b0;
            r_req_tag    <= '0;
            r_req_wdata  <= '0;
            r_way        <= '0;
            r_resp_hit   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_tag    <= '0;
            r_mem_wdata  <= '0;
        end else begin
            if (w_line_we) begin
                r_valid[w_line_way] <= 1'b1;
                r_dirty[w_line_way] <= w_line_dirty;
            end
            if (w_accept) begin
                r_write     <= req_write;
                r_req_tag   <= req_tag;
                r_req_wdata <= req_wdata;
                r_way       <= w_hit ? w_hit_way : w_victim;
                if (w_hit) begin
                    r_resp_hit <= 1'b1;
                    if (!req_write) r_resp_rdata <= r_data[w_hit_way];
                end else if (r_dirty[w_victim]) begin
                    r_mem_valid <= 1'b1;
                    r_mem_write <= 1'b1;
                    r_mem_tag   <= r_tag[w_victim];
                    r_mem_wdata <= r_data[w_victim];
                end else if (!req_write) begin
                    r_mem_valid <= 1'b1;
                    r_mem_write <= 1'b0;
                    r_mem_tag   <= req_tag;
                end else begin
                    r_resp_hit <= 1'b0;
                end
            end
            if (r_state == ST_WB && w_mem_done) begin
                if (r_write) begin
                    r_mem_valid <= 1'b0;
                    r_resp_hit  <= 1'b0;
                end else begin
                    // Refill follows the writeback back to back.
                    r_mem_write <= 1'b0;
                    r_mem_tag   <= r_req_tag;
                end
            end
            if (r_state == ST_FILL && w_mem_done) begin
                r_mem_valid  <= 1'b0;
                r_resp_hit   <= 1'b0;
                r_resp_rdata <= mem_rdata;
            end
        end
    end

    assign req_ready     = (r_state == ST_IDLE);
    assign resp_valid    = (r_state == ST_RESP);
    assign resp_hit      = r_resp_hit;
    assign resp_rdata    = r_resp_rdata;
    assign mem_req_valid = r_mem_valid;
    assign mem_req_write = r_mem_write;
    assign mem_req_tag   = r_mem_tag;
    assign mem_req_wdata = r_mem_wdata;

endmodule

// File: tb/tb_cache_assoc_wb.sv
// Directed scoreboard bench for cache_assoc_wb (WAYS=4, TAG_W=5, DATA_W=8).
module tb_cache_assoc_wb;

    typedef struct {
        logic       wr;
        logic [4:0] tag;
        logic [7:0] wdata;
        logic       chk_wdata;
    } mem_exp_t;

    typedef struct {
        logic       hit;
        logic [7:0] rdata;
        logic       chk_rdata;
        int         lat;
    } resp_exp_t;

    logic       clock1 = 1'b0;
    logic       Reset = 1'b1;
    logic       req_valid = 1'b0, req_write = 1'b0;
    logic [4:0] req_tag = '0;
    logic [7:0] req_wdata = '0;
    logic       req_ready, resp_valid, resp_hit;
    logic [7:0] resp_rdata;
    logic       mem_req_valid, mem_req_write;
    logic [4:0] mem_req_tag;
    logic [7:0] mem_req_wdata;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    mem_exp_t  exp_mem[$];
    resp_exp_t exp_resp[$];

    always #5 clock1 = ~clock1;

    cache_assoc_wb #(.WAYS(4), .TAG_W(5), .DATA_W(8)) dut (
        .clock1        (clock1),
        .Reset         (Reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_tag       (req_tag),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_hit      (resp_hit),
        .resp_rdata    (resp_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_write (mem_req_write),
        .mem_req_tag   (mem_req_tag),
        .mem_req_wdata (mem_req_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_m(input logic wr, input logic [4:0] tag, input logic [7:0] wd);
        mem_exp_t m;
        m.wr = wr; m.tag = tag; m.wdata = wd; m.chk_wdata = wr;
        exp_mem.push_back(m);
    endtask

    task automatic exp_r(input logic hit, input logic [7:0] rd, input logic chk, input int lat);
        resp_exp_t r;
        r.hit = hit; r.rdata = rd; r.chk_rdata = chk; r.lat = lat;
        exp_resp.push_back(r);
    endtask

    // Holds Reset for two edges, checks reset outputs, releases at a negedge.
    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(posedge clock1);
        @(negedge clock1);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_hit", resp_hit, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_mem_valid", mem_req_valid, 0);
        check("rst_mem_write", mem_req_write, 0);
        check("rst_mem_tag", mem_req_tag, 0);
        check("rst_mem_wdata", mem_req_wdata, 0);
        Reset = 1'b0;
    endtask

    // One request from a negedge in IDLE until its response; services memory.
    task automatic access(input logic wr, input logic [4:0] tag, input logic [7:0] wd,
                          input int ack_delay, input logic [7:0] fill_data, input logic poke);
        int         cycles;
        int         wait_cnt;
        logic       in_flight;
        logic       done;
        mem_exp_t   me;
        resp_exp_t  re;
        logic [13:0] cap;
        req_valid = 1'b1; req_write = wr; req_tag = tag; req_wdata = wd;
        check("req_ready_idle", req_ready, 1);
        @(posedge clock1); #1;
        req_valid = 1'b0; req_tag = 5'($urandom); req_wdata = 8'($urandom);
        cycles = 0; wait_cnt = 0; in_flight = 1'b0; done = 1'b0; cap = '0;
        while (!done && cycles < 200) begin
            @(negedge clock1);
            if (mem_ack) begin
                mem_ack = 1'b0; in_flight = 1'b0; req_valid = 1'b0;
            end
            if (resp_valid) begin
                check("resp_expected", exp_resp.size() != 0, 1);
                if (exp_resp.size() != 0) begin
                    re = exp_resp.pop_front();
                    check("resp_hit", resp_hit, re.hit);
                    if (re.chk_rdata) check("resp_rdata", resp_rdata, re.rdata);
                    if (re.lat >= 0) check("resp_latency", cycles, re.lat);
                end
                done = 1'b1;
            end else if (mem_req_valid) begin
                if (!in_flight) begin
                    check("mem_expected", exp_mem.size() != 0, 1);
                    if (exp_mem.size() != 0) begin
                        me = exp_mem.pop_front();
                        check("mem_write", mem_req_write, me.wr);
                        check("mem_tag", mem_req_tag, me.tag);
                        if (me.chk_wdata) check("mem_wdata", mem_req_wdata, me.wdata);
                    end
                    in_flight = 1'b1; wait_cnt = 0;
                    cap = {mem_req_write, mem_req_tag, mem_req_wdata};
                end else begin
                    check("mem_stable", {mem_req_write, mem_req_tag, mem_req_wdata}, cap);
                    if (poke) check("req_ready_busy", req_ready, 0);
                end
                wait_cnt++;
                if (wait_cnt >= ack_delay) begin
                    mem_ack = 1'b1; mem_rdata = fill_data; req_valid = 1'b0;
                end else if (poke) begin
                    req_valid = ~req_valid; req_write = 1'b0; req_tag = tag + 5'd1;
                end
            end
            cycles++;
        end
        if (!done) check("resp_timeout", 0, 1);
        check("mem_all_seen", exp_mem.size(), 0);
        @(negedge clock1);
        check("resp_one_cycle", resp_valid, 0);
    endtask

    initial begin : stim
        mem_exp_t m;
        logic     seen;
        do_reset();

        // Read miss on tag 5 into empty cache: refill only.
        exp_m(0, 5'd5, 8'h00); exp_r(0, 8'h3C, 1, -1);
        access(0, 5'd5, 8'h00, 3, 8'h3C, 0);
        // Read hit, one cycle latency, no memory traffic.
        exp_r(1, 8'h3C, 1, 0);
        access(0, 5'd5, 8'h00, 3, 8'h00, 0);
        // Fill lines 1..3 with clean write misses (dirty installs, no memory).
        exp_r(0, 8'h00, 0, 0); access(1, 5'd1, 8'hA1, 1, 8'h00, 0);
        exp_r(0, 8'h00, 0, 0); access(1, 5'd2, 8'hA2, 1, 8'h00, 0);
        exp_r(0, 8'h00, 0, 0); access(1, 5'd3, 8'hA3, 1, 8'h00, 0);
        // LRU is line 0 (tag 5), refilled clean: evicted without writeback.
        exp_m(0, 5'd9, 8'h00); exp_r(0, 8'h99, 1, -1);
        access(0, 5'd9, 8'h00, 2, 8'h99, 0);

        // Spurious mem_ack while idle is ignored.
        mem_ack = 1'b1;
        @(negedge clock1);
        mem_ack = 1'b0;
        check("idle_ack_mem_valid", mem_req_valid, 0);
        check("idle_ack_resp", resp_valid, 0);

        do_reset();
        exp_r(0, 8'h00, 0, 0); access(1, 5'd1, 8'h11, 1, 8'h00, 0);
        exp_r(0, 8'h00, 0, 0); access(1, 5'd2, 8'h22, 1, 8'h00, 0);
        exp_r(0, 8'h00, 0, 0); access(1, 5'd3, 8'h33, 1, 8'h00, 0);
        exp_r(0, 8'h00, 0, 0); access(1, 5'd4, 8'h44, 1, 8'h00, 0);
        // Write miss on tag 6: writeback of tag 1 held 20 cycles, no refill.
        exp_m(1, 5'd1, 8'h11); exp_r(0, 8'h00, 0, -1);
        access(1, 5'd6, 8'h66, 20, 8'h00, 1);
        // Read tag 2 hit, then read miss tag 9 evicts tag 3 (WB then FILL).
        exp_r(1, 8'h22, 1, 0); access(0, 5'd2, 8'h00, 1, 8'h00, 0);
        exp_m(1, 5'd3, 8'h33); exp_m(0, 5'd9, 8'h00); exp_r(0, 8'h9A, 1, -1);
        access(0, 5'd9, 8'h00, 2, 8'h9A, 0);
        // Installed write-miss data and refill data read back as hits.
        exp_r(1, 8'h66, 1, 0); access(0, 5'd6, 8'h00, 1, 8'h00, 0);
        exp_r(1, 8'h00, 0, 0); access(1, 5'd4, 8'h45, 1, 8'h00, 0);
        exp_r(1, 8'h45, 1, 0); access(0, 5'd4, 8'h00, 1, 8'h00, 0);
        // Read miss tag 11 evicts tag 2 (LRU, dirty).
        exp_m(1, 5'd2, 8'h22); exp_m(0, 5'd11, 8'h00); exp_r(0, 8'hB0, 1, -1);
        access(0, 5'd11, 8'h00, 1, 8'hB0, 0);

        // Reset coincident with the refill ack aborts the transaction.
        exp_m(0, 5'd12, 8'h00);
        req_valid = 1'b1; req_write = 1'b0; req_tag = 5'd12;
        check("req_ready_abort", req_ready, 1);
        @(posedge clock1); #1;
        req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clock1);
            seen = mem_req_valid;
        end
        check("abort_fill_seen", seen, 1);
        if (exp_mem.size() != 0) begin
            m = exp_mem.pop_front();
            check("abort_fill_write", mem_req_write, m.wr);
            check("abort_fill_tag", mem_req_tag, m.tag);
        end
        Reset = 1'b1; mem_ack = 1'b1; mem_rdata = 8'hCC;
        @(negedge clock1);
        check("abort_mem_valid", mem_req_valid, 0);
        check("abort_resp_valid", resp_valid, 0);
        Reset = 1'b0; mem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock1);
            check("abort_no_resp", resp_valid, 0);
        end
        // The aborted tag was never installed: it misses again.
        exp_m(0, 5'd12, 8'h00); exp_r(0, 8'hC1, 1, -1);
        access(0, 5'd12, 8'h00, 2, 8'hC1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_assoc_wb.md
CACHE_ASSOC_WB -- requirements
Module: cache_assoc_wb

Interface
REQ-001 SHALL have parameter WAYS, default 4, number of fully associative lines (power of 2, 2..16).
REQ-002 SHALL have parameter TAG_W, default 5, tag/address width.
REQ-003 SHALL have parameter DATA_W, default 8, block width.
REQ-004 SHALL have ports:
- clock1  in  1  clock; all state changes on posedge.
- Reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  CPU request present.
- req_ready  out  1  cache can accept a request.
- req_write  in  1  0 = read, 1 = write.
- req_tag  in  TAG_W  request address.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_hit  out  1  request hit; valid with resp_valid.
- resp_rdata  out  DATA_W  read data; valid with resp_valid.
- mem_req_valid  out  1  memory transaction pending.
- mem_req_write  out  1  1 = writeback, 0 = refill.
- mem_req_tag  out  TAG_W  memory address.
- mem_req_wdata  out  DATA_W  writeback data.
- mem_ack  in  1  memory completes the transaction this cycle.
- mem_rdata  in  DATA_W  refill data; valid with mem_ack.

Function
REQ-005 SHALL hold per line: valid, dirty, tag, data, and an age of log2(WAYS) bits.
REQ-006 SHALL implement FSM states IDLE, WB, FILL, RESP; req_ready = 1 only in IDLE.
REQ-007 SHALL accept a request when req_valid & req_ready, latch write, tag and wdata, and perform lookup the same cycle.
REQ-008 SHALL treat a request as a hit when exactly one valid line matches the tag; on a hit it SHALL go to RESP. A write hit updates data and sets dirty on that edge; a read hit latches data.
REQ-009 SHALL select the miss victim as the lowest-index invalid line; if none is invalid, the line with age = WAYS-1.
REQ-010 SHALL, on a miss with a dirty victim, go to WB and issue mem_req_write = 1 with the victim's tag and data; otherwise skip WB.
REQ-011 SHALL, after WB or a clean miss, go to FILL (mem_req_write = 0, mem_req_tag = request tag) on a read miss, or install directly and go to RESP on a write miss (write-allocate, no refill).
REQ-012 SHALL hold mem_req_valid and all mem_req_* fields stable from assertion until the mem_ack cycle; mem_ack while mem_req_valid = 0 SHALL be ignored.
REQ-013 SHALL, on the FILL mem_ack edge, install the line with valid = 1, dirty = 0, data = mem_rdata, and go to RESP with resp_rdata = mem_rdata.
REQ-014 SHALL install a write-miss line with valid = 1, dirty = 1, data = req_wdata.
REQ-015 SHALL pulse resp_valid for exactly one cycle in RESP, then return to IDLE; hit latency is 1 cycle from acceptance to resp_valid.
REQ-016 SHALL update ages on every access (hit or install). The accessed line gets age 0. Valid lines younger than its old age are incremented. Ages remain a permutation of 0..WAYS-1.
REQ-017 SHALL hold resp_rdata and resp_hit stable outside resp_valid; resp_rdata is undefined for writes.

Reset
REQ-018 SHALL, when Reset = 1 at a posedge, force IDLE and clear all valid and dirty bits. It SHALL set line i age to i.
REQ-019 SHALL, on reset, drive req_ready = 1 and resp_valid = resp_hit = 0. It SHALL drive mem_req_valid = mem_req_write = 0, with resp_rdata, mem_req_tag and mem_req_wdata = 0.
REQ-020 SHALL, on Reset during WB or FILL, abort the transaction (mem_req_valid low the next cycle) and emit no resp_valid; a coincident mem_ack is discarded.

Structure
REQ-021 SHALL place the FSM state encoding and the age width function (clog2 of WAYS) in shared package cache_pkg.
REQ-022 SHALL implement age tracking in sub-module cache_lru_ages (inputs: access strobe, way index; output: victim index).

Verification
REQ-023 Reset, then read tag 5 with mem_ack after 3 cycles and mem_rdata 0x3C -> FILL with mem_req_tag 5; resp_hit = 0; resp_rdata 0x3C; line 0 valid and clean.
REQ-024 Read tag 5 again -> resp_valid 1 cycle after acceptance; resp_hit = 1; rdata 0x3C; no mem_req_valid.
REQ-025 WAYS = 4: write tags 1,2,3,4 with data 0x11..0x44, then write tag 6 = 0x66 -> WB of tag 1 with data 0x11; no FILL; resp_hit = 0; tag 6 installed dirty.
REQ-026 After REQ-025, read tag 2 then miss on tag 9 -> victim is tag 3 (LRU); WB of 0x33 precedes FILL of tag 9.
REQ-027 Assert Reset during FILL with mem_ack on the same edge -> mem_req_valid = 0 next cycle; no resp_valid; a subsequent read of that tag misses.
REQ-028 Hold mem_ack low for 20 cycles during WB -> mem_req_* remain stable; req_ready stays 0; req_valid pulses are not accepted.
